sample_decimator: RTL and testbench
===================================

Name: sample_decimator

Overview:
- Downstream consumer of the 3-tap smoothing filter stage.
- Takes the filter's 8-bit output stream, averages each non-overlapping block of 2^LOG2_N accepted samples, and emits one 8-bit result per block.
- Input and output use valid/ready handshakes.
- A 2-entry output buffer decouples the decimated stream from the downstream sink.

Parameters:
- LOG2_N, 2, log2 of the decimation ratio; legal range 0..6. LOG2_N=0 passes samples through via the buffer.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous reset, active-high.
- in_data  input  8  filtered sample from the filter stage.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- flush  input  1  discard the partial block accumulated so far.
- out_data  output  8  decimated sample (head of the output buffer).
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts out_data this cycle.
- phase  output  LOG2_N (min 1)  count of samples accumulated in the current block.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports CLK and RST.
- Reset state, all registered: accumulator 0, phase 0, buffer empty, out_valid 0, out_data 0, in_ready 1 (combinational from the empty buffer).
- Accept rule: a sample is accepted when in_valid && in_ready.
  - in_ready = !buffer_full && !flush.
  - When the buffer is full, input stalls even mid-block.
- Accumulator: width 8+LOG2_N, unsigned; cannot overflow over one block.
- On accept with phase < N-1: acc <= acc + in_data; phase <= phase+1.
- On accept with phase == N-1 (block end):
  - sum = acc + in_data.
  - Push result = sum >> LOG2_N, truncated to 8 bits (fits by construction).
  - acc <= 0; phase <= 0.
- Latency: result is visible on out_data/out_valid in the cycle after the block-end accept when the buffer was empty. Otherwise it is queued behind the existing head.
- Output buffer: 2-entry FIFO, first-in first-out.
  - Pop when out_valid && out_ready.
  - out_valid = !empty.
  - out_data holds the head and stays stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - occupancy 1: occupancy stays 1, new data becomes head next cycle.
  - occupancy 0: no pop possible; push only.
  - occupancy 2: no push possible, because in_ready is 0.
- Flush: acc <= 0 and phase <= 0 next cycle.
  - in_ready is 0 that cycle, so no sample is accepted.
  - Buffer contents and pops are unaffected.
  - Flush with phase 0 is a no-op.
- Reset mid-block or with a full buffer: all state is cleared; partial sums and queued results are lost.
- in_data is ignored when not accepted. A stalled in_valid holds the sample; the upstream filter must not advance.

Optional Feature:
- Macro: DECIM_ROUND_EN.
- Defined: result = (sum + 2^(LOG2_N-1)) >> LOG2_N, i.e. round half up.
  - Rounding term is 0 when LOG2_N=0.
  - Max value is 255; no saturation logic needed.
  - The adder stays within 8+LOG2_N bits.
- Undefined: truncating shift as above; no rounding adder is synthesised.

Test Plan (LOG2_N=2 unless noted):
1. Reset, out_ready=1, feed 10,20,30,40 back-to-back -> one out_valid pulse with out_data=25, one cycle after the 40 is accepted; phase returns to 0.
2. Feed 1,2,2,2 -> out_data=1 without DECIM_ROUND_EN; out_data=2 with it. Feed 255×4 -> 255 in both builds.
3. Backpressure:
   - Hold out_ready=0 and feed 12 samples of value 8.
   - in_ready must drop after the 8th accept, with buffer holding 8,8; samples 9-12 are stalled.
   - Raise out_ready -> 8,8 pop in order, then blocks resume; third result 8.
4. Push/pop concurrency: occupancy 1, out_ready=1, block completes in the same cycle -> occupancy remains 1, no result lost or duplicated over 5 consecutive blocks.
5. Feed 100,100, assert flush one cycle, then feed 4,4,4,4 -> single output 4; in_ready=0 during the flush cycle.
6. Assert RST with phase=3 and buffer full -> next cycle out_valid=0, phase=0, in_ready=1. LOG2_N=0 build: input 77 -> output 77 after 1 cycle.

Source files
------------

// File: rtl/sample_decimator.sv
// ---------------------------------------------------------------------------
// sample_decimator
//
// Averages each non-overlapping block of 2**LOG2_N accepted 8-bit samples
// from the smoothing filter and emits one 8-bit result per block through a
// 2-entry output FIFO. Both sides use valid/ready handshakes.
//
// Parameters:
//   LOG2_N    log2 of the decimation ratio, legal range 0..6.
//             LOG2_N = 0 passes every sample straight into the FIFO.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous reset, active-high
//   in_data    filtered sample from the upstream filter
//   in_valid   in_data is valid this cycle
//   in_ready   a sample can be accepted this cycle
//   flush      discard the partial block accumulated so far
//   out_data   head of the output FIFO
//   out_valid  out_data is valid
//   out_ready  sink accepts out_data this cycle
//   phase      number of samples accumulated in the current block
//
// Optional build macro:
//   DECIM_ROUND_EN  round half up, result = (sum + 2**(LOG2_N-1)) >> LOG2_N.
//                   Undefined: plain truncating shift, no rounding adder.
// ---------------------------------------------------------------------------
module sample_decimator #(
    parameter  int LOG2_N = 2,
    localparam int PW     = (LOG2_N > 0) ? LOG2_N : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] phase
);

    // Accumulator holds at most N*255, which fits in 8+LOG2_N bits.
    localparam int            AW   = 8 + LOG2_N;
    localparam int            N    = 1 << LOG2_N;
    localparam logic [PW-1:0] LAST = PW'(N - 1);

`ifdef DECIM_ROUND_EN
    // Half an LSB of the result; evaluates to 0 when LOG2_N = 0.
    localparam logic [AW-1:0] ROUND = AW'((1 << LOG2_N) >> 1);
`endif

    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [AW-1:0] sum_rnd;
    logic [7:0]    result;
    logic          accept;
    logic          block_end;
    logic          push;
    logic          pop;

    // Two-entry FIFO kept as explicit head/tail registers plus an occupancy.
    logic [1:0]    count;
    logic [7:0]    head;
    logic [7:0]    tail;

    // NOTE: every output of a combinational block is assigned on every path,
    // so no latch can be inferred.
    always_comb begin
        in_ready  = (count != 2'd2) && !flush;
        out_valid = (count != 2'd0);
        out_data  = head;
        accept    = in_valid && in_ready;
        block_end = accept && (phase == LAST);
        push      = block_end;
        pop       = out_valid && out_ready;
        sum       = acc + AW'(in_data);
`ifdef DECIM_ROUND_EN
        sum_rnd   = sum + ROUND;
`else
        sum_rnd   = sum;
`endif
        result    = 8'(sum_rnd >> LOG2_N);
    end

    // Block accumulator and phase counter. Flush and accept are mutually
    // exclusive because flush forces in_ready low.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc   <= '0;
            phase <= '0;
        end else if (flush) begin
            acc   <= '0;
            phase <= '0;
        end else if (accept) begin
            if (phase == LAST) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= sum;
                phase <= phase + PW'(1);
            end
        end
    end

    // Output FIFO. A push into a full FIFO cannot occur since in_ready is low
    // whenever count is 2, and a pop from an empty FIFO is blocked by
    // out_valid, so only the legal push/pop combinations are decoded.
    // NOTE: the storage registers are reset too, because out_data must read
    // 0 straight out of reset rather than an unknown value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= result;
                    else               tail <= result;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with count == 1: the new result
                    // replaces the departing head, occupancy unchanged.
                    head <= result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_decimator.sv
// ---------------------------------------------------------------------------
// tb_sample_decimator
//
// Self-checking bench for sample_decimator (LOG2_N = 2 main instance plus a
// LOG2_N = 0 pass-through instance). A block-average model built from a
// running integer sum and a result queue is compared with the DUT on every
// negative clock edge; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_sample_decimator;

    localparam int L = 2;
    localparam int N = 1 << L;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [L-1:0] phase;

    logic [7:0] d0_in_data = '0;
    logic       d0_in_valid = 1'b0;
    logic       d0_in_ready;
    logic [7:0] d0_out_data;
    logic       d0_out_valid;
    logic       d0_out_ready = 1'b0;
    logic [0:0] d0_phase;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int  q[$];
    int  m_sum = 0;
    int  m_cnt = 0;
    int  pops  = 0;
    bit  live  = 1'b0;

    always #5 CLK = ~CLK;

    sample_decimator #(.LOG2_N(L)) dut (
        .CLK(CLK), .RST(RST),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .phase(phase)
    );

    sample_decimator #(.LOG2_N(0)) dut0 (
        .CLK(CLK), .RST(RST),
        .in_data(d0_in_data), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .flush(1'b0),
        .out_data(d0_out_data), .out_valid(d0_out_valid), .out_ready(d0_out_ready),
        .phase(d0_phase)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int model_result(input int s);
`ifdef DECIM_ROUND_EN
        return (s + N / 2) / N;
`else
        return s / N;
`endif
    endfunction

    // Compare DUT against the model, then advance the model to what the
    // upcoming rising edge must produce (inputs are stable by now).
    initial forever begin
        bit acc_ok;
        bit pop_ok;
        @(negedge CLK);
        if (live) begin
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(q.size() < 2 && !flush));
            check("phase", 32'(phase), 32'(m_cnt));
            if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
        end
        if (RST) begin
            q.delete();
            m_sum = 0;
            m_cnt = 0;
            live  = 1'b1;
        end else if (live) begin
            pop_ok = (q.size() != 0) && out_ready;
            acc_ok = in_valid && (q.size() < 2) && !flush;
            if (pop_ok) begin
                void'(q.pop_front());
                pops++;
            end
            if (flush) begin
                m_sum = 0;
                m_cnt = 0;
            end else if (acc_ok) begin
                m_sum += int'(in_data);
                m_cnt++;
                if (m_cnt == N) begin
                    q.push_back(model_result(m_sum));
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    // Present one sample and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] v);
        bit ok;
        int n;
        n = 0;
        in_data  = v;
        in_valid = 1'b1;
        do begin
            @(negedge CLK);
            ok = in_ready;
            @(posedge CLK);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [7:0] v, input int cnt);
        for (int i = 0; i < cnt; i++) send(v);
    endtask

    task automatic pulse_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge CLK);
        #1;
    endtask

    initial begin
        int p0;
        int rnd_val;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        @(negedge CLK);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge CLK); #1;

        // 1: 10,20,30,40 -> 25, single pulse, phase back to 0
        out_ready = 1'b1;
        send(8'd10); send(8'd20); send(8'd30); send(8'd40);
        @(negedge CLK);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'd25);
        check("t1_phase", 32'(phase), 32'd0);
        @(negedge CLK);
        check("t1_pulse_end", 32'(out_valid), 32'd0);
        @(posedge CLK); #1;

        // 2: 1,2,2,2 truncates or rounds; 255x4 -> 255
        send(8'd1); send(8'd2); send(8'd2); send(8'd2);
        @(negedge CLK);
`ifdef DECIM_ROUND_EN
        check("t2_round", 32'(out_data), 32'd2);
`else
        check("t2_trunc", 32'(out_data), 32'd1);
`endif
        @(posedge CLK); #1;
        send_block(8'd255, 4);
        @(negedge CLK);
        check("t2_max", 32'(out_data), 32'd255);
        @(posedge CLK); #1;
        idle(2);

        // 3: backpressure, 12 samples of 8 with the sink stalled
        out_ready = 1'b0;
        p0 = pops;
        send_block(8'd8, 8);
        @(negedge CLK);
        check("t3_stall", 32'(in_ready), 32'd0);
        check("t3_head", 32'(out_data), 32'd8);
        @(posedge CLK); #1;
        fork
            send_block(8'd8, 4);
            begin
                idle(4);
                out_ready = 1'b1;
            end
        join
        idle(8);
        check("t3_pops", 32'(pops - p0), 32'd3);

        // 4: push and pop in the same cycle at occupancy 1, five blocks
        out_ready = 1'b0;
        send_block(8'd7, 4);
        p0 = pops;
        for (int k = 1; k <= 5; k++) begin
            send_block(8'(3 * k), 3);
            out_ready = 1'b1;
            send(8'(3 * k));
            out_ready = 1'b0;
        end
        @(negedge CLK);
        check("t4_occ", 32'(out_valid), 32'd1);
        check("t4_head", 32'(out_data), 32'd15);
        check("t4_pops", 32'(pops - p0), 32'd5);
        @(posedge CLK); #1;
        out_ready = 1'b1;
        idle(3);

        // 5: flush discards a partial block
        p0 = pops;
        send(8'd100); send(8'd100);
        flush = 1'b1;
        @(negedge CLK);
        check("t5_flush_ready", 32'(in_ready), 32'd0);
        check("t5_phase_before", 32'(phase), 32'd2);
        @(posedge CLK); #1;
        flush = 1'b0;
        @(negedge CLK);
        check("t5_phase_after", 32'(phase), 32'd0);
        @(posedge CLK); #1;
        send_block(8'd4, 4);
        @(negedge CLK);
        check("t5_data", 32'(out_data), 32'd4);
        @(posedge CLK); #1;
        idle(3);
        check("t5_pops", 32'(pops - p0), 32'd1);

        // 6a: reset with the buffer full
        out_ready = 1'b0;
        send_block(8'd9, 8);
        @(negedge CLK);
        check("t6_full", 32'(in_ready), 32'd0);
        pulse_reset();
        @(negedge CLK);
        check("t6a_valid", 32'(out_valid), 32'd0);
        check("t6a_phase", 32'(phase), 32'd0);
        check("t6a_ready", 32'(in_ready), 32'd1);
        @(posedge CLK); #1;

        // 6b: reset mid-block at phase 3
        send_block(8'd50, 3);
        @(negedge CLK);
        check("t6b_phase3", 32'(phase), 32'd3);
        pulse_reset();
        @(negedge CLK);
        check("t6b_valid", 32'(out_valid), 32'd0);
        check("t6b_phase", 32'(phase), 32'd0);
        check("t6b_ready", 32'(in_ready), 32'd1);
        @(posedge CLK); #1;

        // 6c: LOG2_N = 0 instance passes 77 through after one cycle
        d0_out_ready = 1'b1;
        d0_in_data   = 8'd77;
        d0_in_valid  = 1'b1;
        @(negedge CLK);
        check("d0_ready", 32'(d0_in_ready), 32'd1);
        @(posedge CLK); #1;
        d0_in_valid = 1'b0;
        @(negedge CLK);
        check("d0_valid", 32'(d0_out_valid), 32'd1);
        check("d0_data", 32'(d0_out_data), 32'd77);
        @(posedge CLK); #1;

        // Randomized traffic checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            rnd_val   = int'($urandom_range(0, 3));
            in_valid  = (rnd_val != 0);
            in_data   = 8'($urandom);
            out_ready = (c % 1000 < 500) ? ($urandom_range(0, 3) == 0)
                                         : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            RST       = ($urandom_range(0, 700) == 0);
            @(posedge CLK); #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        RST       = 1'b0;
        out_ready = 1'b1;
        idle(6);
        @(negedge CLK);
        check("drain_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
